// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment bit positions, glyph encodings for
// hex digits, the pattern-to-nibble decoder and the capture buffer states.
package sevenseg_pkg;

   localparam int SEG_BIT_A = 0;
   localparam int SEG_BIT_B = 1;
   localparam int SEG_BIT_C = 2;
   localparam int SEG_BIT_D = 3;
   localparam int SEG_BIT_E = 4;
   localparam int SEG_BIT_F = 5;
   localparam int SEG_BIT_G = 6;

   // Encodings are gfedcba, 1 = lit.
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   typedef struct packed {
      logic       err;
      logic [3:0] nibble;
   } seg_dec_t;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

   // Unknown glyphs (including blank) decode to 0 with err set.
   function automatic seg_dec_t seg_decode(input logic [6:0] seg);
      seg_dec_t r;
      r.err    = 1'b0;
      r.nibble = 4'h0;
      case (seg)
         SEG_0:   r.nibble = 4'h0;
         SEG_1:   r.nibble = 4'h1;
         SEG_2:   r.nibble = 4'h2;
         SEG_3:   r.nibble = 4'h3;
         SEG_4:   r.nibble = 4'h4;
         SEG_5:   r.nibble = 4'h5;
         SEG_6:   r.nibble = 4'h6;
         SEG_7:   r.nibble = 4'h7;
         SEG_8:   r.nibble = 4'h8;
         SEG_9:   r.nibble = 4'h9;
         SEG_A:   r.nibble = 4'hA;
         SEG_B:   r.nibble = 4'hB;
         SEG_C:   r.nibble = 4'hC;
         SEG_D:   r.nibble = 4'hD;
         SEG_E:   r.nibble = 4'hE;
         SEG_F:   r.nibble = 4'hF;
         default: r.err    = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sevenseg_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous lines; both
// stages clear to 0 on reset.
module sevenseg_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sevenseg_capture.sv
// Samples a multiplexed seven-segment bus, decodes each stably driven digit
// into a shadow frame and hands complete frames out over valid/ready.
module sevenseg_capture
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int STABLE_CYCLES  = 4,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_n_i,
   input  logic [6:0]              seg_i,
   input  logic                    dp_i,
   input  logic [NUM_DIGITS-1:0]   dig_i,
   output logic                    frame_valid_o,
   input  logic                    frame_ready_i,
   output logic [4*NUM_DIGITS-1:0] digits_o,
   output logic [NUM_DIGITS-1:0]   dp_o,
   output logic                    frame_err_o,
   output logic                    overrun_o,
   output logic                    mhot_o
);

   localparam int SW  = 8 + NUM_DIGITS;
   localparam int CW  = $clog2(STABLE_CYCLES + 1);
   localparam int SLW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [SW-1:0]                  smp, smp_prev;
   logic [6:0]                     seg_n;
   logic                           dp_n;
   logic [NUM_DIGITS-1:0]          dig_n;
   logic [CW-1:0]                  cnt, cnt_next;
   logic                           diff, stable;
   logic                           one_hot, multi_hot, capture, complete;
   logic [SLW-1:0]                 slot;
   seg_dec_t                       dec;
   logic [NUM_DIGITS-1:0]          cap;
   logic [NUM_DIGITS-1:0][3:0]     sh_nib;
   logic [NUM_DIGITS-1:0]          sh_dp;
   logic                           sh_err;
   buf_state_t                     state, state_next;
   logic                           xfer, load;

   sevenseg_sync #(.W(SW)) u_sync (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n_i),
      .d     ({dig_i, dp_i, seg_i}),
      .q     (smp)
   );

   assign seg_n = (SEG_ACTIVE_LOW != 0) ? ~smp[6:0]    : smp[6:0];
   assign dp_n  = (SEG_ACTIVE_LOW != 0) ? ~smp[7]      : smp[7];
   assign dig_n = (DIG_ACTIVE_LOW != 0) ? ~smp[SW-1:8] : smp[SW-1:8];

   // A sample counts as stable exactly once per run, on the cycle the run
   // length reaches STABLE_CYCLES; the counter then saturates above it.
   always_comb begin
      diff = (smp != smp_prev);
      if (diff)
         cnt_next = '0;
      else if (cnt == CW'(STABLE_CYCLES))
         cnt_next = cnt;
      else
         cnt_next = cnt + 1'b1;
      stable = (cnt_next == CW'(STABLE_CYCLES - 1)) &&
               (diff || (cnt != CW'(STABLE_CYCLES - 1)));
   end

   always_comb begin
      slot = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (dig_n[k]) slot = SLW'(k);
      one_hot   = $onehot(dig_n);
      multi_hot = (dig_n != '0) && !one_hot;
   end

   assign dec      = seg_decode(seg_n);
   assign capture  = stable && one_hot && !cap[slot];
   assign complete = &cap;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         smp_prev <= '0;
         cnt      <= '0;
         cap      <= '0;
         sh_nib   <= '0;
         sh_dp    <= '0;
         sh_err   <= 1'b0;
         mhot_o   <= 1'b0;
      end else begin
         smp_prev <= smp;
         cnt      <= cnt_next;
         mhot_o   <= stable && multi_hot;
         if (complete) begin
            cap    <= '0;
            sh_err <= 1'b0;
         end else if (capture) begin
            cap[slot]    <= 1'b1;
            sh_nib[slot] <= dec.nibble;
            sh_dp[slot]  <= dp_n;
            if (dec.err) sh_err <= 1'b1;
         end
      end
   end

   // Handshake: a frame transfers on any rising edge where frame_valid_o and
   // frame_ready_i are both high; while valid && !ready the outputs hold.
   // A completing frame may load in the same cycle an older one transfers.
   always_comb begin
      state_next = state;
      xfer       = (state == BUF_FULL) && frame_ready_i;
      load       = complete && ((state == BUF_EMPTY) || xfer);
      case (state)
         BUF_EMPTY: if (load) state_next = BUF_FULL;
         BUF_FULL:  if (xfer && !load) state_next = BUF_EMPTY;
         default:   state_next = BUF_EMPTY;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state <= BUF_EMPTY;
      else             state <= state_next;
   end

   assign frame_valid_o = (state == BUF_FULL);

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         digits_o    <= '0;
         dp_o        <= '0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         overrun_o <= complete && !load;
         if (load) begin
            digits_o    <= sh_nib;
            dp_o        <= sh_dp;
            frame_err_o <= sh_err;
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed scenarios plus randomized digit traffic
// scored against a frame-level model of the capture rules.
module tb_sevenseg_capture;

   localparam int N  = 4;
   localparam int S  = 4;
   localparam int FW = 1 + N + 4 * N;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [6:0]     seg_a, seg_b;
   logic           dp_a, dp_b;
   logic [N-1:0]   dig_a, dig_b;
   logic           ready_a, ready_b;
   logic           valid_a, valid_b, err_a, err_b, ov_a, ov_b, mh_a, mh_b;
   logic [4*N-1:0] digits_a, digits_b;
   logic [N-1:0]   dpo_a, dpo_b;

   int checks   = 0;
   int failures = 0;

   logic [FW-1:0] exp_q[$];
   logic [FW-1:0] got_q[$];
   int   ov_hi, ov_rise, mh_hi, mh_rise, exp_mhot;
   logic ov_prev, mh_prev;

   logic [6:0] seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [3:0] m_nib[N];
   logic       m_dp[N];
   bit         m_cap[N];
   bit         m_err;

   sevenseg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut_a (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .seg_i(seg_a), .dp_i(dp_a), .dig_i(dig_a),
      .frame_valid_o(valid_a), .frame_ready_i(ready_a), .digits_o(digits_a),
      .dp_o(dpo_a), .frame_err_o(err_a), .overrun_o(ov_a), .mhot_o(mh_a)
   );

   sevenseg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1),
                      .DIG_ACTIVE_LOW(1)) dut_b (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .seg_i(seg_b), .dp_i(dp_b), .dig_i(dig_b),
      .frame_valid_o(valid_b), .frame_ready_i(ready_b), .digits_o(digits_b),
      .dp_o(dpo_b), .frame_err_o(err_b), .overrun_o(ov_b), .mhot_o(mh_b)
   );

   always #5 clk = ~clk;

   // Monitor: records transfers and pulse activity, one sample per cycle.
   always begin
      @(negedge clk);
      #1;
      if (valid_a && ready_a) got_q.push_back({err_a, dpo_a, digits_a});
      if (ov_a) ov_hi++;
      if (ov_a && !ov_prev) ov_rise++;
      if (mh_a) mh_hi++;
      if (mh_a && !mh_prev) mh_rise++;
      ov_prev = ov_a;
      mh_prev = mh_a;
   end

   initial begin
      #2_000_000;
      checks++;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic int seg_value(input logic [6:0] p);
      for (int i = 0; i < 16; i++)
         if (seg_tab[i] == p) return i;
      return -1;
   endfunction

   function automatic logic [FW-1:0] model_frame();
      logic [FW-1:0] f;
      f = '0;
      for (int i = 0; i < N; i++) begin
         f[4*i +: 4] = m_nib[i];
         f[4*N + i]  = m_dp[i];
      end
      f[FW-1] = m_err;
      return f;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_cap[i] = 1'b0;
         m_nib[i] = 4'h0;
         m_dp[i]  = 1'b0;
      end
      m_err = 1'b0;
      exp_q.delete();
      got_q.delete();
      ov_hi = 0; ov_rise = 0; mh_hi = 0; mh_rise = 0; exp_mhot = 0;
   endtask

   // A held pattern is captured iff it lasts at least S cycles, selects one
   // digit whose slot is still empty; a full slot set emits one frame.
   task automatic model_note(input logic [N-1:0] dig, input logic [6:0] seg,
                             input logic dp, input int hold);
      int v, k;
      bit all;
      if (hold < S || dig == '0) return;
      if (!$onehot(dig)) begin
         exp_mhot++;
         return;
      end
      k = 0;
      for (int i = 0; i < N; i++) if (dig[i]) k = i;
      if (m_cap[k]) return;
      v = seg_value(seg);
      m_cap[k] = 1'b1;
      m_nib[k] = (v < 0) ? 4'h0 : 4'(v);
      m_dp[k]  = dp;
      if (v < 0) m_err = 1'b1;
      all = 1'b1;
      for (int i = 0; i < N; i++) if (!m_cap[i]) all = 1'b0;
      if (all) begin
         exp_q.push_back(model_frame());
         for (int i = 0; i < N; i++) m_cap[i] = 1'b0;
         m_err = 1'b0;
      end
   endtask

   task automatic show(input logic [N-1:0] dig, input logic [6:0] seg,
                       input logic dp, input int hold);
      @(negedge clk);
      dig_a = dig; seg_a = seg; dp_a = dp;
      repeat (hold - 1) @(negedge clk);
      model_note(dig, seg, dp, hold);
   endtask

   task automatic show_b(input logic [N-1:0] dig, input logic [6:0] seg, input int hold);
      @(negedge clk);
      dig_b = ~dig; seg_b = ~seg; dp_b = 1'b1;
      repeat (hold - 1) @(negedge clk);
   endtask

   task automatic show_frame(input int hold);
      logic [N-1:0] oh;
      for (int d = 0; d < N; d++) begin
         oh = '0;
         oh[d] = 1'b1;
         show(oh, seg_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1)), hold);
      end
   endtask

   task automatic blank_pins();
      seg_a = '0; dp_a = 1'b0; dig_a = '0;
      seg_b = '1; dp_b = 1'b1; dig_b = '1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      blank_pins();
      ready_a = 1'b0;
      ready_b = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      model_clear();
   endtask

   task automatic drain();
      @(negedge clk);
      blank_pins();
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      blank_pins();
      ready_a = 1'b0;
      ready_b = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      #1;
      checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_a); end
      checks++; if (digits_a !== '0) begin failures++; $display("FAIL reset_digits: got %h want 0", digits_a); end
      checks++; if (dpo_a !== '0) begin failures++; $display("FAIL reset_dp: got %b want 0", dpo_a); end
      checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_a); end
      checks++; if ({ov_a, mh_a} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b want 00", {ov_a, mh_a}); end
      checks++; if ({valid_b, digits_b} !== '0) begin failures++; $display("FAIL reset_b: got %h want 0", {valid_b, digits_b}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      checks++; if (valid_a !== 1'b0 || mh_rise != 0) begin
         failures++; $display("FAIL reset_idle: valid %b mhot pulses %0d want 0/0", valid_a, mh_rise);
      end
   endtask

   task automatic test_basic();
      apply_reset();
      ready_a = 1'b1;
      repeat (3)
         for (int d = 0; d < N; d++) show(N'(1 << d), seg_tab[d + 1], 1'b0, 8);
      drain();
      checks++; if (got_q.size() != 3) begin failures++; $display("FAIL basic_count: got %0d frames want 3", got_q.size()); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== {1'b0, 4'b0000, 16'h4321}) begin
            failures++; $display("FAIL basic_frame%0d: got %h want %h", i, got_q[i], {1'b0, 4'b0000, 16'h4321});
         end
      end
      checks++; if (ov_rise != 0) begin failures++; $display("FAIL basic_overrun: got %0d pulses want 0", ov_rise); end
   endtask

   task automatic test_random();
      logic [N-1:0] dig;
      logic [6:0]   seg;
      int           r;
      apply_reset();
      ready_a = 1'b1;
      repeat (80) begin
         r = $urandom_range(0, 9);
         if (r < 7) dig = N'(1 << $urandom_range(0, N - 1));
         else if (r == 7) dig = '0;
         else dig = N'($urandom_range(1, (1 << N) - 1));
         seg = ($urandom_range(0, 9) < 8) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
         show(dig, seg, 1'($urandom_range(0, 1)), $urandom_range(2, 7));
         show('0, 7'h00, 1'b0, 1);
      end
      drain();
      checks++; if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL random_count: got %0d frames want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL random_frame%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++; if (mh_rise != exp_mhot || mh_hi != exp_mhot) begin
         failures++; $display("FAIL random_mhot: got %0d pulses %0d high cycles want %0d", mh_rise, mh_hi, exp_mhot);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      ready_a = 1'b1;
      show(4'b0001, seg_tab[5], 1'b0, 6);
      show(4'b0010, seg_tab[6], 1'b1, 6);
      for (int i = 0; i < 5; i++) show(4'b0100, (i % 2 == 1) ? seg_tab[1] : seg_tab[2], 1'b0, 2);
      show(4'b0100, 7'h7F, 1'b0, 8);
      show(4'b1000, seg_tab[9], 1'b0, 6);
      drain();
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL glitch_count: got %0d frames want 1", got_q.size()); end
      if (got_q.size() > 0 && exp_q.size() > 0) begin
         checks++; if (got_q[0][11:8] !== 4'h8) begin failures++; $display("FAIL glitch_slot2: got %h want 8", got_q[0][11:8]); end
         checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL glitch_frame: got %h want %h", got_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_backpressure();
      logic [6:0] last_seg;
      apply_reset();
      ready_a = 1'b0;
      show_frame(6);
      show_frame(6);
      drain();
      checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL bp_valid_held: got %b want 1", valid_a); end
      checks++; if ({err_a, dpo_a, digits_a} !== exp_q[0]) begin
         failures++; $display("FAIL bp_first_held: got %h want %h", {err_a, dpo_a, digits_a}, exp_q[0]);
      end
      checks++; if (ov_rise != 1 || ov_hi != 1) begin
         failures++; $display("FAIL bp_overrun: got %0d pulses %0d high cycles want 1/1", ov_rise, ov_hi);
      end
      for (int d = 0; d < N - 1; d++) show(N'(1 << d), seg_tab[$urandom_range(0, 15)], 1'b0, 6);
      last_seg = seg_tab[$urandom_range(0, 15)];
      @(negedge clk);
      dig_a = N'(1 << (N - 1)); seg_a = last_seg; dp_a = 1'b1;
      model_note(dig_a, seg_a, dp_a, 9);
      repeat (6) @(negedge clk);
      ready_a = 1'b1;
      @(negedge clk);
      ready_a = 1'b0;
      #1;
      checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL bp_valid_stays: got %b want 1", valid_a); end
      checks++; if ({err_a, dpo_a, digits_a} !== exp_q[2]) begin
         failures++; $display("FAIL bp_third_loaded: got %h want %h", {err_a, dpo_a, digits_a}, exp_q[2]);
      end
      drain();
      checks++; if (ov_rise != 1) begin failures++; $display("FAIL bp_no_second_overrun: got %0d pulses want 1", ov_rise); end
      ready_a = 1'b1;
      drain();
      // The second frame was dropped by the overrun, so only 1st and 3rd arrive.
      exp_q.delete(1);
      checks++; if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL bp_count: got %0d frames want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL bp_frame%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_bad_mhot();
      apply_reset();
      ready_a = 1'b1;
      show(4'b0001, seg_tab[7], 1'b0, 6);
      show(4'b0010, 7'h01, 1'b0, 6);
      show(4'b0100, seg_tab[3], 1'b0, 6);
      show(4'b1000, seg_tab[10], 1'b0, 6);
      drain();
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL bad_count: got %0d frames want 1", got_q.size()); end
      if (got_q.size() > 0) begin
         checks++; if (got_q[0][FW-1] !== 1'b1) begin failures++; $display("FAIL bad_err: got %b want 1", got_q[0][FW-1]); end
         checks++; if (got_q[0][7:4] !== 4'h0) begin failures++; $display("FAIL bad_nibble: got %h want 0", got_q[0][7:4]); end
         checks++; if (got_q[0] !== {1'b1, 4'b0000, 16'hA307}) begin
            failures++; $display("FAIL bad_frame: got %h want %h", got_q[0], {1'b1, 4'b0000, 16'hA307});
         end
      end
      show(4'b0011, 7'h7F, 1'b0, 8);
      drain();
      checks++; if (mh_rise != 1 || mh_hi != 1) begin
         failures++; $display("FAIL mhot_pulse: got %0d pulses %0d high cycles want 1/1", mh_rise, mh_hi);
      end
      show(4'b0001, seg_tab[2], 1'b0, 6);
      show(4'b0010, seg_tab[4], 1'b0, 6);
      show(4'b0100, seg_tab[6], 1'b0, 6);
      show(4'b1000, seg_tab[8], 1'b0, 6);
      drain();
      checks++; if (got_q.size() != 2) begin failures++; $display("FAIL mhot_count: got %0d frames want 2", got_q.size()); end
      if (got_q.size() > 1) begin
         checks++; if (got_q[1] !== {1'b0, 4'b0000, 16'h8642}) begin
            failures++; $display("FAIL mhot_no_capture: got %h want %h", got_q[1], {1'b0, 4'b0000, 16'h8642});
         end
      end
   endtask

   task automatic test_polarity();
      apply_reset();
      ready_b = 1'b0;
      show_b(4'b0001, seg_tab[0], 6);
      show_b(4'b0010, seg_tab[12], 6);
      show_b(4'b0100, seg_tab[5], 6);
      show_b(4'b1000, seg_tab[10], 6);
      drain();
      checks++; if (valid_b !== 1'b1) begin failures++; $display("FAIL pol_valid: got %b want 1", valid_b); end
      checks++; if ({err_b, dpo_b, digits_b} !== {1'b0, 4'b0000, 16'hA5C0}) begin
         failures++; $display("FAIL pol_frame: got %h want %h", {err_b, dpo_b, digits_b}, {1'b0, 4'b0000, 16'hA5C0});
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      ready_a = 1'b0;
      show_frame(6);
      drain();
      checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL rmid_held: got %b want 1", valid_a); end
      show(4'b0001, seg_tab[14], 1'b1, 6);
      show(4'b0010, seg_tab[15], 1'b1, 6);
      @(negedge clk);
      rst_n = 1'b0;
      blank_pins();
      #1;
      checks++; if ({valid_a, err_a, dpo_a, digits_a, ov_a, mh_a} !== '0) begin
         failures++; $display("FAIL rmid_outputs: got %h want 0", {valid_a, err_a, dpo_a, digits_a, ov_a, mh_a});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      model_clear();
      ready_a = 1'b1;
      for (int d = 0; d < N; d++) show(N'(1 << d), seg_tab[$urandom_range(0, 9)], 1'b0, 6);
      drain();
      checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin
         failures++; $display("FAIL rmid_count: got %0d frames want %0d", got_q.size(), exp_q.size());
      end else begin
         checks++; if (got_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL rmid_frame: got %h want %h", got_q[0], exp_q[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_glitch();
      test_backpressure();
      test_bad_mhot();
      test_polarity();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side counterpart of the multiplexed seven-segment display driver. It samples the segment and digit-select lines on `io_in` and works out which digit is being driven. It decodes each segment pattern back to a hex nibble and assembles a complete frame of `NUM_DIGITS` nibbles. Each finished frame is presented on a valid/ready interface. It is used for on-chip loopback self-test and for reading an external display bus through the user project wrapper.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of multiplexed digits; 2..8.
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a digit is captured; ≥1.
- `SEG_ACTIVE_LOW`, 0: 1 means segment and `dp` lines are active-low on the pins.
- `DIG_ACTIVE_LOW`, 0: 1 means digit-select lines are active-low on the pins.

Ports:
- `wb_clk_i`, in, 1: sole clock; rising edge.
- `wb_rst_n_i`, in, 1: reset; asynchronous, active-low.
- `seg_i`, in, 7: segments, with bit 0 = a through bit 6 = g; asynchronous to `wb_clk_i`.
- `dp_i`, in, 1: decimal point; asynchronous.
- `dig_i`, in, NUM_DIGITS: digit selects; asynchronous.
- `frame_valid_o`, out, 1: a frame is held on the outputs.
- `frame_ready_i`, in, 1: consumer accepts the frame.
- `digits_o`, out, 4*NUM_DIGITS: nibble k on bits [4k+3:4k].
- `dp_o`, out, NUM_DIGITS: decimal point per digit.
- `frame_err_o`, out, 1: the held frame contains at least one undecodable pattern.
- `overrun_o`, out, 1: one-cycle pulse when a completed frame is dropped.
- `mhot_o`, out, 1: one-cycle pulse when a stable multi-hot `dig_i` is seen.

## Operation
- **Input synchronization**
  - All of `seg_i`, `dp_i` and `dig_i` pass through a 2-flop synchronizer.
  - After synchronization, polarity is normalized so that 1 = lit/selected.
- **Stability counter**
  - The counter compares the current synchronized sample {seg, dp, dig} with the previous one.
  - Any difference resets the counter to 0; otherwise it increments, saturating at STABLE_CYCLES.
  - The counter reaching STABLE_CYCLES-1 marks the sample as "stable". This fires once per stable run.
- **Capture on a stable sample**
  - dig == 0 (blanking interval): ignored.
  - dig multi-hot: no capture; `mhot_o` pulses.
  - dig one-hot at index k, and `cap[k]` == 0: the decoded nibble and dp are written into shadow slot k and `cap[k]` is set.
  - dig one-hot at index k, and `cap[k]` == 1: ignored; the first capture in a frame wins.
- **Segment decode** (gfedcba → nibble):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Any other pattern, including 00: the nibble is 0 and the shadow error flag is set.
- **Frame completion**, when `cap` is all-ones:
  - If the output buffer is empty, or is being accepted this cycle: the shadow contents load into `digits_o`, `dp_o` and `frame_err_o`, and `frame_valid_o` is 1 next cycle.
  - Otherwise: the frame is discarded and `overrun_o` pulses.
  - In both cases `cap` and the shadow error flag clear.
- **Output handshake**
  - A transfer occurs when `frame_valid_o` and `frame_ready_i` are both high.
  - Outputs stay stable while valid && !ready.
  - Transfer with no completion in the same cycle: `frame_valid_o` falls next cycle.
  - Transfer and completion in the same cycle: the new frame loads and valid stays high.
- **Control states**
  - Output buffer: EMPTY → FULL on load; FULL → EMPTY on a transfer without a simultaneous load.
  - The capture side is a bitmap over slots, not a state machine.

## Timing
- Reset (async assert, sync release): all outputs 0, `cap` = 0, synchronizers 0, counter 0, buffer EMPTY.
- Reset mid-frame discards the partial frame and any held frame.
- Latency: pins settle at edge N, the synchronized sample appears at N+2, capture occurs at N+2+STABLE_CYCLES-1.
  - When that capture completes a frame, `frame_valid_o` is high after edge N+STABLE_CYCLES+2.
- `overrun_o` and `mhot_o` are exactly one cycle wide; they are registered outputs.
- Inputs are never combinationally connected to outputs. `frame_ready_i` affects only the next state.

## Structure
- Package `sevenseg_pkg`: segment encoding constants SEG_0..SEG_F, the decode function, and the bit-position constants a..g.
- The same package is shared with the display driver.
- One sub-module, `sevenseg_sync`: a parameterized-width 2-flop synchronizer with reset to 0.

## Test plan
- **Basic decode:** defaults; drive digits 0..3 cyclically with 06/5B/4F/66 (values 1/2/3/4), 8 cycles each, ready=1 → `digits_o`=16'h4321, `frame_err_o`=0, valid pulses once per frame.
- **Glitch rejection:** toggle `seg_i` on digit 2 every 2 cycles for 10 cycles, then hold 7F → slot 2 = 8, with no earlier capture of that slot.
- **Backpressure and overrun:** ready=0 across two full frames → the first frame is held unchanged and `overrun_o` pulses once at the second completion. Raise ready in the cycle the third frame completes → the third frame loads and valid stays 1.
- **Bad pattern and multi-hot:** digit 1 shows 0x01 → `frame_err_o`=1 with nibble 0. `dig_i`=4'b0011 held stable → `mhot_o` pulses and nothing is captured.
- **Polarity:** SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, inverted pins for "A5C0" → `digits_o`=16'hA5C0.
- **Reset mid-frame:** assert `wb_rst_n_i` low after 2 digits → all outputs 0. After release, the next full frame decodes correctly and none of the partial data leaks into it.
